pipe_shifter: RTL and testbench
===============================

# pipe_shifter

Parametrised, pipelined barrel shifter for the SimpleRISC execute stage. It supports logical-left, logical-right, arithmetic-right and (optionally) rotate-right shifts over a configurable data width. Pipeline registers are placed between log2 mux layers as selected by a mask, and valid/ready handshakes on both sides let the ALU stall and flush it. It also produces the carry-out and zero flags used by the flag register.

## Interface
Parameters:
- `WIDTH`, 32: data width; power of two, 8..64.
- `SHAMT_W`, $clog2(WIDTH): shift-amount width (derived, not overridden).
- `PIPE_MASK`, 5'b00100: bit k set places a register after mux layer k (layer k shifts by 2^k); SHAMT_W bits wide.
- `TAG_W`, 4: width of the sideband tag carried alongside data (destination register id).

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `flush`, input, 1: discard every in-flight operation.
- `in_valid`, input, 1: operation offered.
- `in_ready`, output, 1: operation accepted when `in_valid && in_ready`.
- `in_data`, input, WIDTH: operand.
- `in_shamt`, input, SHAMT_W: shift amount.
- `in_mode`, input, 2: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- `in_tag`, input, TAG_W: sideband, returned unchanged.
- `out_valid`, output, 1: result present.
- `out_ready`, input, 1: consumer takes the result when `out_valid && out_ready`.
- `out_data`, output, WIDTH: shifted result.
- `out_carry`, output, 1: last bit shifted out.
- `out_zero`, output, 1: `out_data == 0`.
- `out_tag`, output, TAG_W: tag of this result.

## Operation
- Datapath: SHAMT_W mux layers, with layer k applying shift 2^k when `shamt[k]` is set.
  - Layers run in ascending k order.
  - Mode and shamt travel with the data through every pipeline register.
- Fill per mode:
  - LSL: zeros fill the LSBs.
  - LSR: zeros fill the MSBs.
  - ASR: copies of operand bit WIDTH-1 fill the MSBs.
  - ROR: bits wrap from LSB to MSB.
- `out_carry` is computed combinationally at input acceptance and carried down the pipe:
  - shamt = 0: 0.
  - LSL: `in_data[WIDTH-shamt]`.
  - LSR/ASR: `in_data[shamt-1]`.
  - ROR: result bit WIDTH-1.
- `out_zero` is computed from the final layer, before the output register.
- Stall is global: `advance = !out_valid || out_ready`; every pipeline register, including the output register, loads only when `advance` is high.
- `in_ready = advance && !flush`.
- Bubbles propagate as invalid entries and are not collapsed.
- `flush` clears all stage valid bits, including `out_valid`, on the next edge.
  - Flush together with `in_valid`: the input is not accepted.
  - Flush together with output handshake: the current output counts as consumed; nothing new appears.
- Reset (`rst_n` low at the edge):
  - All valid bits go to 0.
  - `out_data`, `out_carry`, `out_zero` and `out_tag` go to 0.
  - Reset asserted mid-stream drops all in-flight operations.
  - Internal data registers need not be reset.

## Timing
- Latency L = 1 + popcount(PIPE_MASK) cycles from accepting edge to `out_valid`; the default is L = 2.
- The output register always exists; there is no combinational path from `in_*` to `out_*`.
- Throughput is 1 operation per cycle while `out_ready` is held high.
- `out_ready` low: `out_*` hold stable, `in_ready` falls in the same cycle (combinational from `out_ready`), and no accepted operation is lost.
- `in_ready` depends on `out_ready` and `flush` only, never on `in_valid`.
- When `out_ready` rises again, the pipe resumes at the next edge in original order.

## Configuration
- Macro `PIPE_SHIFTER_ROR_EN` compiles the rotate feature in or out.
- Defined: mode 11 performs ROR as specified.
- Undefined: the wrap-around mux paths are not built and mode 11 behaves exactly as LSR, including the carry rule.

## Structure
- Package `pipe_shifter_pkg`:
  - `shift_mode_t` enum: `SH_LSL`, `SH_LSR`, `SH_ASR`, `SH_ROR`.
  - Localparam for the mode width (2).
  - Function computing the fill bit for a given mode and operand.
- Sub-module `shift_layer`: one combinational mux layer, parameterised by `WIDTH` and `DIST`, with inputs data, enable and mode.
  - It is instantiated SHAMT_W times in a generate loop.
  - Pipeline registers are generated from `PIPE_MASK` in the top level.

## Test plan
- Shift modes, WIDTH=32, default mask, `out_ready` high, operand 32'h8000_0001, shamt 4:
  - LSL -> `out_data` 32'h0000_0010, `out_carry` 0.
  - LSR -> 32'h0800_0000, carry 0.
  - ASR -> 32'hF800_0000, carry 0.
  - ROR -> 32'h1800_0000, carry 0.
  - Each result appears exactly 2 cycles after acceptance.
- Boundaries: LSL 32'h0000_0001 by 31 -> 32'h8000_0000; LSR same by 31 -> 32'h0, `out_zero` 1, carry 0; shamt 0 on 32'hDEAD_BEEF -> unchanged, carry 0.
- Back-pressure: stream 8 ops tagged 0..7 with `out_ready` low for cycles 3–6 -> all 8 emerge in tag order, none duplicated or lost, `out_*` stable while stalled.
- Flush: 2 ops in flight, `flush` with `in_valid` high -> next cycle `out_valid` 0, the input is not accepted, and the op offered after flush emerges 2 cycles after its acceptance.
- Reset mid-stream: `rst_n` low for one edge with the pipe full -> `out_valid`, `out_data`, `out_tag` all 0; no stale results appear afterwards.
- Configuration: rerun with `PIPE_SHIFTER_ROR_EN` undefined (mode 11 equals LSR: 32'h8000_0001 by 4 -> 32'h0800_0000) and with PIPE_MASK=0 (latency 1) and 5'b11111 (latency 6).

Source files
------------

// File: rtl/pipe_shifter_pkg.sv
// pipe_shifter shared types: shift modes and fill-bit helper.
// Rotate support is selected by PIPE_SHIFTER_ROR_EN in the users of this package.
package pipe_shifter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_mode_t;

  function automatic logic fill_bit(
    input shift_mode_t mode,
    input logic        msb
  );
    return (mode == SH_ASR) ? msb : 1'b0;
  endfunction

endpackage

// File: rtl/shift_layer.sv
// One combinational barrel-shifter mux layer shifting by DIST.
// Wrap-around paths exist only when PIPE_SHIFTER_ROR_EN is defined.
module shift_layer
  import pipe_shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             en_i,
  input  shift_mode_t      mode_i,
  output logic [WIDTH-1:0] data_o
);

  logic fill;

  // MSB still equals the operand sign after earlier right-shift layers
  always_comb begin
    fill   = fill_bit(mode_i, data_i[WIDTH-1]);
    data_o = data_i;
    if (en_i) begin
      unique case (mode_i)
        SH_LSL: data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
`ifdef PIPE_SHIFTER_ROR_EN
        SH_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`endif
        default: data_o = {{DIST{fill}}, data_i[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready, carry and zero flags.
// Define PIPE_SHIFTER_ROR_EN to build rotate-right; otherwise mode 11 acts as LSR.
module pipe_shifter
  import pipe_shifter_pkg::*;
#(
  parameter int                 WIDTH     = 32,
  parameter int                 SHAMT_W   = $clog2(WIDTH),
  parameter logic [SHAMT_W-1:0] PIPE_MASK = SHAMT_W'(5'b00100),
  parameter int                 TAG_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [MODE_W-1:0]  in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_carry,
  output logic               out_zero,
  output logic [TAG_W-1:0]   out_tag
);

  logic advance;

  logic [WIDTH-1:0]   st_data  [SHAMT_W+1];
  logic               st_valid [SHAMT_W+1];
  logic               st_carry [SHAMT_W+1];
  logic [TAG_W-1:0]   st_tag   [SHAMT_W+1];
  logic [SHAMT_W-1:0] st_shamt [SHAMT_W+1];
  shift_mode_t        st_mode  [SHAMT_W+1];
  logic [WIDTH-1:0]   ly_data  [SHAMT_W];

  logic [SHAMT_W-1:0] lsl_idx;
  logic [SHAMT_W-1:0] rsh_idx;
  logic               in_carry;

  logic               out_valid_d, out_valid_q;
  logic [WIDTH-1:0]   out_data_d, out_data_q;
  logic               out_carry_d, out_carry_q;
  logic               out_zero_d, out_zero_q;
  logic [TAG_W-1:0]   out_tag_d, out_tag_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !flush;

  // ROR's result MSB is in_data[shamt-1], same as the right shifts
  always_comb begin
    lsl_idx  = SHAMT_W'(0) - in_shamt;
    rsh_idx  = in_shamt - SHAMT_W'(1);
    in_carry = 1'b0;
    if (in_shamt != '0) begin
      in_carry = (in_mode == SH_LSL) ? in_data[lsl_idx] : in_data[rsh_idx];
    end
  end

  assign st_data[0]  = in_data;
  assign st_valid[0] = in_valid && in_ready;
  assign st_carry[0] = in_carry;
  assign st_tag[0]   = in_tag;
  assign st_shamt[0] = in_shamt;
  assign st_mode[0]  = shift_mode_t'(in_mode);

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_layer
    shift_layer #(
      .WIDTH(WIDTH),
      .DIST (1 << k)
    ) u_layer (
      .data_i(st_data[k]),
      .en_i  (st_shamt[k][k]),
      .mode_i(st_mode[k]),
      .data_o(ly_data[k])
    );

    if (PIPE_MASK[k]) begin : g_reg
      logic               valid_q;
      logic [WIDTH-1:0]   data_q;
      logic               carry_q;
      logic [TAG_W-1:0]   tag_q;
      logic [SHAMT_W-1:0] shamt_q;
      shift_mode_t        mode_q;

      always_ff @(posedge clk) begin
        if (!rst_n)       valid_q <= 1'b0;
        else if (flush)   valid_q <= 1'b0;
        else if (advance) valid_q <= st_valid[k];
      end

      always_ff @(posedge clk) begin
        if (advance) begin
          data_q  <= ly_data[k];
          carry_q <= st_carry[k];
          tag_q   <= st_tag[k];
          shamt_q <= st_shamt[k];
          mode_q  <= st_mode[k];
        end
      end

      assign st_valid[k+1] = valid_q;
      assign st_data[k+1]  = data_q;
      assign st_carry[k+1] = carry_q;
      assign st_tag[k+1]   = tag_q;
      assign st_shamt[k+1] = shamt_q;
      assign st_mode[k+1]  = mode_q;
    end else begin : g_wire
      assign st_valid[k+1] = st_valid[k];
      assign st_data[k+1]  = ly_data[k];
      assign st_carry[k+1] = st_carry[k];
      assign st_tag[k+1]   = st_tag[k];
      assign st_shamt[k+1] = st_shamt[k];
      assign st_mode[k+1]  = st_mode[k];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_carry_d = out_carry_q;
    out_zero_d  = out_zero_q;
    out_tag_d   = out_tag_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (advance) begin
      out_valid_d = st_valid[SHAMT_W];
      out_data_d  = st_data[SHAMT_W];
      out_carry_d = st_carry[SHAMT_W];
      out_zero_d  = (st_data[SHAMT_W] == '0);
      out_tag_d   = st_tag[SHAMT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_carry_q <= 1'b0;
      out_zero_q  <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_carry_q <= out_carry_d;
      out_zero_q  <= out_zero_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_carry = out_carry_q;
  assign out_zero  = out_zero_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_pipe_shifter.sv
// Bench for pipe_shifter: directed steps plus random traffic vs a delay-line model.
// Mode 11 expectations follow PIPE_SHIFTER_ROR_EN.
module tb_pipe_shifter;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_mode;
  logic [3:0]  in_tag;

  logic        in_ready, out_valid, out_carry, out_zero;
  logic [31:0] out_data;
  logic [3:0]  out_tag;

  logic        m0_in_ready, m0_out_valid, m0_out_carry, m0_out_zero;
  logic [31:0] m0_out_data;
  logic [3:0]  m0_out_tag;

  logic        m31_in_ready, m31_out_valid, m31_out_carry, m31_out_zero;
  logic [31:0] m31_out_data;
  logic [3:0]  m31_out_tag;

  int n_cmp = 0;
  int n_err = 0;

  // two-slot delay line: slot 0 mid register, slot 1 output register
  bit          mv[2];
  logic [31:0] md[2];
  bit          mc[2];
  bit          mz[2];
  logic [3:0]  mt[2];
  logic [3:0]  cons[$];

  always #5 clk = ~clk;

  pipe_shifter u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry),
    .out_zero(out_zero), .out_tag(out_tag)
  );

  pipe_shifter #(.PIPE_MASK(5'b00000)) u_m0 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(m0_in_ready),
    .in_data(in_data), .in_shamt(in_shamt),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(m0_out_valid), .out_ready(out_ready),
    .out_data(m0_out_data), .out_carry(m0_out_carry),
    .out_zero(m0_out_zero), .out_tag(m0_out_tag)
  );

  pipe_shifter #(.PIPE_MASK(5'b11111)) u_m31 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(m31_in_ready),
    .in_data(in_data), .in_shamt(in_shamt),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(m31_out_valid), .out_ready(out_ready),
    .out_data(m31_out_data), .out_carry(m31_out_carry),
    .out_zero(m31_out_zero), .out_tag(m31_out_tag)
  );

  function automatic logic [32:0] ref_op(logic [31:0] d, int s, logic [1:0] m);
    logic [31:0] r;
    logic        c;
    logic [63:0] w;
    logic [32:0] x;
    logic [1:0]  mm;
    mm = m;
`ifndef PIPE_SHIFTER_ROR_EN
    if (mm == 2'b11) mm = 2'b01;
`endif
    case (mm)
      2'b00: begin
        w = {32'b0, d} << s;
        r = w[31:0];
        c = w[32];
      end
      2'b01: begin
        x = {d, 1'b0} >> s;
        r = x[32:1];
        c = x[0];
      end
      2'b10: begin
        x = $signed({d, 1'b0}) >>> s;
        r = x[32:1];
        c = x[0];
      end
      default: begin
        r = (d >> s) | (d << (32 - s));
        c = (s != 0) && r[31];
      end
    endcase
    return {c, r};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, logic [31:0] d, logic [4:0] s,
                       logic [1:0] m, logic [3:0] t);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_mode  = m;
    in_tag   = t;
  endtask

  // one clock: check handshake, advance model, check outputs
  task automatic step(output bit acc);
    bit          adv, rdy;
    logic [32:0] rc;
    #1;
    adv = !mv[1] || out_ready;
    rdy = adv && !flush;
    if (rst_n) chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    if (rst_n && mv[1] && out_ready) cons.push_back(out_tag);
    rc = ref_op(in_data, int'(in_shamt), in_mode);
    @(posedge clk);
    if (!rst_n) begin
      mv[0] = 0; mv[1] = 0;
      md[1] = '0; mc[1] = 0; mz[1] = 0; mt[1] = '0;
    end else if (flush) begin
      mv[0] = 0; mv[1] = 0;
    end else if (adv) begin
      mv[1] = mv[0]; md[1] = md[0]; mc[1] = mc[0];
      mz[1] = mz[0]; mt[1] = mt[0];
      mv[0] = acc; md[0] = rc[31:0]; mc[0] = rc[32];
      mz[0] = (rc[31:0] == 0); mt[0] = in_tag;
    end
    @(negedge clk);
    chk("out_valid", out_valid, mv[1]);
    if (mv[1]) begin
      chk("out_data", out_data, md[1]);
      chk("out_carry", out_carry, mc[1]);
      chk("out_zero", out_zero, mz[1]);
      chk("out_tag", out_tag, mt[1]);
    end
  endtask

  task automatic one(string nm, logic [31:0] d, logic [4:0] s, logic [1:0] m,
                     logic [31:0] ed, logic ec, logic ez);
    bit a;
    drive(1, d, s, m, 4'h5);
    step(a);
    in_valid = 0;
    chk({nm, "_lat1"}, out_valid, 1'b0);
    step(a);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_data"}, out_data, ed);
    chk({nm, "_carry"}, out_carry, ec);
    chk({nm, "_zero"}, out_zero, ez);
  endtask

  initial begin
    bit          a;
    int          lm, l0, l31, idx;
    logic [31:0] d0, d31;
    logic [31:0] ror_exp;

    rst_n = 0; flush = 0; out_ready = 0;
    drive(0, '0, '0, '0, '0);
    @(negedge clk);
    step(a);
    step(a);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_tag", out_tag, 4'h0);
    chk("rst_carry", out_carry, 1'b0);
    chk("rst_zero", out_zero, 1'b0);
    rst_n = 1;
    out_ready = 1;
    step(a);

    // latency for the three pipe masks
    lm = 0; l0 = 0; l31 = 0; d0 = '0; d31 = '0;
    drive(1, 32'h8000_0001, 5'd4, 2'b00, 4'h1);
    step(a);
    in_valid = 0;
    for (int c = 1; c <= 10; c++) begin
      if (out_valid && lm == 0) lm = c;
      if (m0_out_valid && l0 == 0) begin l0 = c; d0 = m0_out_data; end
      if (m31_out_valid && l31 == 0) begin l31 = c; d31 = m31_out_data; end
      step(a);
    end
    chk("lat_default", lm, 2);
    chk("lat_mask0", l0, 1);
    chk("lat_mask31", l31, 6);
    chk("mask0_data", d0, 32'h0000_0010);
    chk("mask31_data", d31, 32'h0000_0010);

`ifdef PIPE_SHIFTER_ROR_EN
    ror_exp = 32'h1800_0000;
`else
    ror_exp = 32'h0800_0000;
`endif
    one("lsl", 32'h8000_0001, 5'd4, 2'b00, 32'h0000_0010, 1'b0, 1'b0);
    one("lsr", 32'h8000_0001, 5'd4, 2'b01, 32'h0800_0000, 1'b0, 1'b0);
    one("asr", 32'h8000_0001, 5'd4, 2'b10, 32'hF800_0000, 1'b0, 1'b0);
    one("ror", 32'h8000_0001, 5'd4, 2'b11, ror_exp, 1'b0, 1'b0);
    one("lsl31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b0, 1'b0);
    one("lsr31", 32'h0000_0001, 5'd31, 2'b01, 32'h0, 1'b0, 1'b1);
    one("sh0", 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF, 1'b0, 1'b0);
    one("lslc", 32'h1000_0000, 5'd4, 2'b00, 32'h0, 1'b1, 1'b1);
    one("asrc", 32'h8000_0008, 5'd4, 2'b10, 32'hF800_0000, 1'b1, 1'b0);
    step(a);
    step(a);

    // back-pressure: 8 tagged ops, consumer stalls cycles 3..6
    cons.delete();
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 6);
      if (idx < 8) drive(1, $urandom, 5'($urandom), 2'($urandom), 4'(idx));
      else in_valid = 0;
      step(a);
      if (a) idx++;
    end
    chk("bp_sent", idx, 8);
    chk("bp_count", cons.size(), 8);
    for (int i = 0; i < 8 && i < cons.size(); i++) chk("bp_order", cons[i], i);

    // flush with two ops in flight and a new op offered
    out_ready = 1;
    drive(1, 32'h0000_00F0, 5'd1, 2'b00, 4'h1);
    step(a);
    drive(1, 32'h0000_00F0, 5'd2, 2'b00, 4'h2);
    step(a);
    flush = 1;
    drive(1, 32'h1234_5678, 5'd3, 2'b01, 4'h9);
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    step(a);
    flush = 0;
    chk("flush_valid", out_valid, 1'b0);
    drive(1, 32'h1234_5678, 5'd8, 2'b01, 4'hA);
    step(a);
    in_valid = 0;
    chk("postflush_lat1", out_valid, 1'b0);
    step(a);
    chk("postflush_valid", out_valid, 1'b1);
    chk("postflush_tag", out_tag, 4'hA);
    chk("postflush_data", out_data, 32'h0012_3456);
    step(a);

    // reset mid-stream
    for (int c = 0; c < 3; c++) begin
      drive(1, $urandom, 5'($urandom), 2'($urandom), 4'(c + 3));
      step(a);
    end
    rst_n = 0;
    step(a);
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_data", out_data, 32'h0);
    chk("midrst_tag", out_tag, 4'h0);
    rst_n = 1;
    in_valid = 0;
    for (int c = 0; c < 8; c++) step(a);

    // random traffic with stalls and occasional flushes
    for (int c = 0; c < 500; c++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 49) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, 5'($urandom),
            2'($urandom), 4'($urandom));
      step(a);
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    for (int c = 0; c < 5; c++) step(a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
